lcd_region_scheduler: RTL

LCD_REGION_SCHEDULER -- requirements
Module: lcd_region_scheduler

---
 rtl/lcd_region_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lcd_region_scheduler.sv
// Schedules redraw regions (64 board squares, two banners, full frame) onto a
// row-major pixel stream. Define SCHED_ROUND_ROBIN_EN for round-robin square service.
module lcd_region_scheduler #(
  parameter int LCD_WIDTH     = 240,
  parameter int LCD_HEIGHT    = 320,
  parameter int BANNER_HEIGHT = 40,
  parameter int SQUARE_SIZE   = 30
) (
  input  logic        clock,
  input  logic        resetApp,
  input  logic [63:0] squareDirty,
  input  logic [1:0]  bannerDirty,
  input  logic        fullRefresh,
  input  logic        holdOff,
  input  logic        pixelReady,
  output logic        pixelWrite,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic        busy,
  output logic [6:0]  regionId,
  output logic        regionDone
);

  localparam int TOP_BIT  = 64;
  localparam int BOT_BIT  = 65;
  localparam int FULL_BIT = 66;

  localparam logic [7:0] XMAX   = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] YMAX   = 9'(LCD_HEIGHT - 1);
  localparam logic [8:0] TOP_Y1 = 9'(BANNER_HEIGHT - 1);
  localparam logic [8:0] BOT_Y0 = 9'(LCD_HEIGHT - BANNER_HEIGHT);
  localparam logic [7:0] SQ_W1  = 8'(SQUARE_SIZE - 1);
  localparam logic [8:0] SQ_H1  = 9'(SQUARE_SIZE - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t      state_q;
  logic        pw_q, busy_q, done_q;
  logic [7:0]  x_q, x0_q, x1_q;
  logic [8:0]  y_q, y1_q;
  logic [6:0]  id_q;
  logic [66:0] pending_q, pending_d, req, sel_clr;
  logic [5:0]  sq_idx;
  logic [7:0]  sq_x0, sel_x0, sel_x1;
  logic [8:0]  sq_y0, sel_y0, sel_y1;
  logic [6:0]  sel_id;
  logic        start;

  assign req   = {fullRefresh, bannerDirty, squareDirty};
  assign start = (state_q == IDLE) && (pending_q != '0) && !holdOff;

`ifdef SCHED_ROUND_ROBIN_EN
  logic [5:0] rr_q;
  logic       sel_sq;

  // Search upward from the pointer; descending loop lets the nearest offset win.
  always_comb begin
    sq_idx = rr_q;
    for (int i = 63; i >= 0; i--) begin
      if (pending_q[rr_q + 6'(i)]) sq_idx = rr_q + 6'(i);
    end
  end
`else
  always_comb begin
    sq_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (pending_q[i]) sq_idx = 6'(i);
    end
  end
`endif

  assign sq_x0 = 8'(SQUARE_SIZE * int'(sq_idx[2:0]));
  assign sq_y0 = 9'(BANNER_HEIGHT + SQUARE_SIZE * int'(sq_idx[5:3]));

  // Full frame covers everything, so its clear mask is all ones.
  always_comb begin
    sel_id  = 7'd127;
    sel_x0  = '0;
    sel_y0  = '0;
    sel_x1  = XMAX;
    sel_y1  = YMAX;
    sel_clr = '1;
`ifdef SCHED_ROUND_ROBIN_EN
    sel_sq  = 1'b0;
`endif
    if (pending_q[FULL_BIT]) begin
      sel_id = 7'd127;
    end else if (pending_q[TOP_BIT]) begin
      sel_id  = 7'd64;
      sel_y1  = TOP_Y1;
      sel_clr = 67'd1 << TOP_BIT;
    end else if (pending_q[BOT_BIT]) begin
      sel_id  = 7'd65;
      sel_y0  = BOT_Y0;
      sel_clr = 67'd1 << BOT_BIT;
    end else begin
      sel_id  = {1'b0, sq_idx};
      sel_x0  = sq_x0;
      sel_y0  = sq_y0;
      sel_x1  = sq_x0 + SQ_W1;
      sel_y1  = sq_y0 + SQ_H1;
      sel_clr = 67'd1 << sq_idx;
`ifdef SCHED_ROUND_ROBIN_EN
      sel_sq  = 1'b1;
`endif
    end
  end

  // Same-edge requests re-set a bit that selection is clearing.
  assign pending_d = start ? ((pending_q & ~sel_clr) | req) : (pending_q | req);

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_q   <= IDLE;
      pw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      id_q      <= '0;
      pending_q <= 67'd1 << FULL_BIT;
`ifdef SCHED_ROUND_ROBIN_EN
      rr_q      <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRAW;
            pw_q    <= 1'b1;
            busy_q  <= 1'b1;
            id_q    <= sel_id;
            x_q     <= sel_x0;
            y_q     <= sel_y0;
            x0_q    <= sel_x0;
            x1_q    <= sel_x1;
            y1_q    <= sel_y1;
`ifdef SCHED_ROUND_ROBIN_EN
            if (sel_sq) rr_q <= sq_idx + 6'd1;
`endif
          end
        end
        DRAW: begin
          if (pixelReady) begin
            if (x_q != x1_q) begin
              x_q <= x_q + 8'd1;
            end else if (y_q != y1_q) begin
              x_q <= x0_q;
              y_q <= y_q + 9'd1;
            end else begin
              // Last pixel accepted: address stays on it, region id is kept.
              state_q <= IDLE;
              pw_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pixelWrite = pw_q;
  assign busy       = busy_q;
  assign regionDone = done_q;
  assign xAddr      = x_q;
  assign yAddr      = y_q;
  assign regionId   = id_q;

endmodule
